tff_updown_counter: RTL and testbench
=====================================

// Module: tff_updown_counter
// PURPOSE
//  Synchronous up/down counter built as a bank of T flip-flops plus the toggle-generation
//  logic that drives their T inputs.
//  - Sits directly upstream of the T-flop cells: computes per-bit toggle enables from
//    count direction and current state.
//  - Exports the count, a terminal-count flag and a registered wrap pulse to downstream
//    dividers and timers.
// PARAMETERS
//  WIDTH      4    counter width in bits (>=2)
// PORTS
//  clk        in   1      rising-edge clock, the single clock of the block
//  rst_n      in   1      asynchronous, active-low reset
//  clr        in   1      synchronous clear to zero
//  load       in   1      synchronous parallel load of d
//  d          in   WIDTH  load value
//  en         in   1      count enable
//  up_dn      in   1      1 = count up, 0 = count down
//  q          out  WIDTH  current count
//  t_vec      out  WIDTH  per-bit toggle enables applied this cycle (observability)
//  tc         out  1      terminal count, combinational: en & (up_dn ? &q : ~|q)
//  wrap       out  1      registered one-cycle pulse, high the cycle after q wraps
// BEHAVIOUR
//  - Reset (rst_n=0, async): q=0, wrap=0; t_vec and tc follow from q=0.
//  - Priority per rising edge: clr > load > en > hold.
//  - Clear: q<=0, wrap<=0. Load: q<=d, wrap<=0. Direction is ignored for both.
//  - Count: t_vec[0]=en.
//    - Up: t_vec[i] = en & (&q[i-1:0]).
//    - Down: t_vec[i] = en & (~|q[i-1:0]).
//    - Each bit toggles when its t_vec bit is 1.
//    - Result is q+1 or q-1 modulo 2**WIDTH, with one-cycle latency.
//  - When clr or load is active, t_vec is forced to 0.
//  - Wrap: wrap<=1 on an edge where en & tc and neither clr nor load is active; otherwise wrap<=0.
//    - Up 2**WIDTH-1 -> 0, down 0 -> 2**WIDTH-1.
//  - up_dn may change on any cycle and takes effect on the next edge. No dead cycle.
//  - If rst_n is asserted mid-count, state clears immediately. The first count occurs on the
//    first edge after rst_n deasserts with en=1.
//  - en=0 holds q, drives t_vec=0 and tc=0.
// CONFIGURATION
//  TFF_CNT_SAT_EN defined: saturating counter.
//    - When en & tc, t_vec is forced to 0 and q holds at 2**WIDTH-1 (up) or 0 (down).
//    - wrap is tied to 0.
//    - clr and load are unaffected.
//  TFF_CNT_SAT_EN undefined: modulo wrap as described above.
// STRUCTURE
//  - Package tff_cnt_pkg:
//    - typedef enum logic {CNT_DN=0, CNT_UP=1} cnt_dir_t
//    - localparam DEF_WIDTH=4
//  - Sub-module tff_cell: one T flip-flop.
//    - Async active-low reset to 0.
//    - Synchronous clr and load-bit inputs.
//    - Toggles when t=1.
//    - Outputs q and qb=~q, always complementary, including during reset.
//  - Top level: instantiates WIDTH copies of tff_cell via generate; holds the toggle logic,
//    tc and the wrap register.
// TESTING (WIDTH=4)
//  1. rst_n=0 mid-count at q=9 -> q=0 and wrap=0 immediately, with no clock edge.
//  2. en=1, up_dn=1 from 0 for 16 edges -> q steps 1..15,0; tc=1 while q=15;
//     wrap=1 for exactly one cycle after q=0.
//  3. en=1, up_dn=0 from q=0 -> q=15 next edge, wrap pulse; t_vec=4'b1111 at q=0.
//  4. load=1, d=4'hA, with en=1 and clr=0 -> q=A, wrap=0.
//     Then clr=1 and load=1 together -> q=0.
//  5. Up-count to q=6, then flip up_dn=0 -> q=5,4,3. With en=0 -> q holds, t_vec=0, tc=0.
//  6. TFF_CNT_SAT_EN defined: up from 14 -> 15,15,15 with wrap=0.
//     Down from 1 -> 0,0 with wrap=0.

Source files
------------

// File: rtl/tff_cnt_pkg.sv
// Shared types and defaults for the T-flop up/down counter.
// Pure declarations; no logic, no latency, no flow control.
// Saturating build selected by defining TFF_CNT_SAT_EN.
package tff_cnt_pkg;

  typedef enum logic {
    CNT_DN = 1'b0,
    CNT_UP = 1'b1
  } cnt_dir_t;

  localparam int DEF_WIDTH = 4;

endpackage

// File: rtl/tff_cell.sv
// Single T flip-flop with synchronous clear and per-bit load.
// Latency: one edge from t/clr/load to q; async reset clears q at once.
// Backpressure: none; the cell acts on every rising edge.
module tff_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic load,
  input  logic d_bit,
  input  logic t,
  output logic q,
  output logic qb
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = 1'b0;
    end else if (load) begin
      q_d = d_bit;
    end else if (t) begin
      q_d = ~q_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  // Both rails come from the same flop, so they stay complementary through reset.
  assign q  = q_q;
  assign qb = ~q_q;

endmodule

// File: rtl/tff_updown_counter.sv
// Up/down counter from a bank of T flops with toggle logic, terminal count and wrap pulse.
// Latency: count/load/clr visible one edge later; wrap pulses the cycle after a wrap.
// Backpressure: none; en=0 holds. Defining TFF_CNT_SAT_EN saturates instead of wrapping.
module tff_updown_counter
  import tff_cnt_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             up_dn,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] t_vec,
  output logic             tc,
  output logic             wrap
);

  cnt_dir_t         dir;
  logic [WIDTH-1:0] qb;
  logic             run_ones;
  logic             run_zeros;
  logic             wrap_q;
  logic             wrap_d;

  always_comb begin
    dir       = cnt_dir_t'(up_dn);
    tc        = en & ((dir == CNT_UP) ? (&q) : (&qb));
    run_ones  = 1'b1;
    run_zeros = 1'b1;
    t_vec     = '0;
    // Bit i toggles when every lower bit is at its carry (up) or borrow (down) value.
    for (int i = 0; i < WIDTH; i++) begin
      t_vec[i]  = en & ((dir == CNT_UP) ? run_ones : run_zeros);
      run_ones  = run_ones & q[i];
      run_zeros = run_zeros & qb[i];
    end
`ifdef TFF_CNT_SAT_EN
    if (tc) begin
      t_vec = '0;
    end
    wrap_d = 1'b0;
`else
    wrap_d = tc & ~clr & ~load;
`endif
    if (clr | load) begin
      t_vec = '0;
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    tff_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .load  (load),
      .d_bit (d[g]),
      .t     (t_vec[g]),
      .q     (q[g]),
      .qb    (qb[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign wrap = wrap_q;

endmodule

// File: tb/tb_tff_updown_counter.sv
// Directed plus random checks of tff_updown_counter against an arithmetic count model.
module tb_tff_updown_counter;

  localparam int W = 4;
  localparam int MAXV = (1 << W) - 1;

  logic         clk;
  logic         rst_n;
  logic         clr;
  logic         load;
  logic [W-1:0] d;
  logic         en;
  logic         up_dn;
  logic [W-1:0] q;
  logic [W-1:0] t_vec;
  logic         tc;
  logic         wrap;

  int errors = 0;
  int checks = 0;
  int m_q    = 0;
  bit m_wrap = 0;

  tff_updown_counter #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .load  (load),
    .d     (d),
    .en    (en),
    .up_dn (up_dn),
    .q     (q),
    .t_vec (t_vec),
    .tc    (tc),
    .wrap  (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (model q=%0d)", tag, obs, exp, m_q);
    end
  endtask

  // Apply inputs just after a falling edge, check combinational outputs, clock, check state.
  task automatic step(input logic c, input logic l, input logic e, input logic u,
                      input logic [W-1:0] dv);
    int       nq;
    bit       nw;
    bit       etc;
    logic [W-1:0] et;
    clr = c; load = l; en = e; up_dn = u; d = dv;
    #1;
    etc = e && (u ? (m_q == MAXV) : (m_q == 0));
    nq  = m_q;
    nw  = 1'b0;
    if (c) begin
      nq = 0;
    end else if (l) begin
      nq = int'(dv);
    end else if (e) begin
`ifdef TFF_CNT_SAT_EN
      if (!etc) nq = u ? m_q + 1 : m_q - 1;
`else
      nq = u ? (m_q + 1) % (MAXV + 1) : (m_q + MAXV) % (MAXV + 1);
      nw = etc;
`endif
    end
    // Toggle enables are exactly the bits that change under a count.
    et = (!c && !l && e) ? W'(m_q ^ nq) : '0;
    chk("tc", {3'b0, tc}, {3'b0, etc});
    chk("t_vec", t_vec, et);
    @(posedge clk);
    m_q = nq;
    m_wrap = nw;
    @(negedge clk);
    chk("q", q, W'(m_q));
    chk("wrap", {3'b0, wrap}, {3'b0, m_wrap});
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; load = 1'b0; d = '0; en = 1'b0; up_dn = 1'b1;
    #3;
    chk("rst_q", q, '0);
    chk("rst_wrap", {3'b0, wrap}, '0);
    chk("rst_tvec", t_vec, '0);
    chk("rst_tc", {3'b0, tc}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Count to 9, then async reset between edges.
    for (int i = 0; i < 9; i++) step(0, 0, 1, 1, '0);
    #2 rst_n = 1'b0;
    #1;
    m_q = 0; m_wrap = 0;
    chk("async_rst_q", q, '0);
    chk("async_rst_wrap", {3'b0, wrap}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full up sweep through the wrap.
    for (int i = 0; i < 17; i++) step(0, 0, 1, 1, '0);
    // Down from zero.
    step(0, 1, 0, 0, 4'h0);
    step(0, 0, 1, 0, '0);
    step(0, 0, 1, 0, '0);
    // Load with en active, then clr beats load.
    step(0, 1, 1, 1, 4'hA);
    step(1, 1, 1, 1, 4'h5);
    // Up to 6, reverse, then hold.
    for (int i = 0; i < 6; i++) step(0, 0, 1, 1, '0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, '0);
    for (int i = 0; i < 2; i++) step(0, 0, 0, i[0], '0);
    // Terminal behaviour near the top and bottom.
    step(0, 1, 0, 1, 4'hE);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, '0);
    step(0, 1, 0, 0, 4'h1);
    for (int i = 0; i < 2; i++) step(0, 0, 1, 0, '0);

    // Random traffic biased toward counting.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 14) == 0),
           ($urandom_range(0, 3) != 0), 1'($urandom), W'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
